// File: rtl/icache_maint_pkg.sv
// -----------------------------------------------------------------------------
// icache_maint_pkg
// Shared types and helpers for the instruction-cache maintenance sequencer.
//   maint_state_e : maintenance FSM states
//   addr_to_set() : extracts the set index from a byte address
// -----------------------------------------------------------------------------
package icache_maint_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DRAIN      = 3'd1,
    FLUSH_WALK = 3'd2,
    SEL_INV    = 3'd3,
    FLUSH_ACK  = 3'd4,
    SEL_ACK    = 3'd5
  } maint_state_e;

  // Set index = address bits just above the line offset. The caller casts the
  // result down to the set-index width.
  function automatic logic [31:0] addr_to_set(input logic [31:0] addr,
                                              input int unsigned off_bits,
                                              input int unsigned set_bits);
    logic [31:0] mask;
    mask = (32'd1 << set_bits) - 32'd1;
    return (addr >> off_bits) & mask;
  endfunction

endpackage

// File: rtl/icache_perf_counter.sv
// -----------------------------------------------------------------------------
// icache_perf_counter
// 32-bit accumulator that adds the number of set bits of a pulse vector each
// enabled cycle. Clear wins over increment: the cleared cycle's pulses are
// dropped. Wraps modulo 2^32.
//   clk_i, rst_i : clock, synchronous active-high reset
//   pulse_i      : per-source event pulses
//   en_i         : count enable
//   clr_i        : synchronous clear
//   count_o      : accumulated count
// -----------------------------------------------------------------------------
module icache_perf_counter #(
  parameter int N = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  pulse_i,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [31:0]   count_o
);

  logic [31:0] r_count;
  logic [31:0] w_inc;

  always_comb begin
    w_inc = '0;
    for (int i = 0; i < N; i++) begin
      w_inc = w_inc + 32'(pulse_i[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= r_count + w_inc;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/icache_maint_sequencer.sv
// -----------------------------------------------------------------------------
// icache_maint_sequencer
// Sequences instruction-cache maintenance: full flush (walk every set, all
// ways), selective flush (one set, all ways), per-core bypass acknowledge and
// optional hit/transaction performance counters.
//
// Tag write handshake: tag_we_o is a request held high with tag_set_o and
// tag_way_o stable until tag_gnt_i is sampled high in the same cycle; that
// cycle completes exactly one write. The fetch path owns the grant.
//
// Ports
//   clk_i, rst_i            : clock, synchronous active-high reset
//   bypass_req_i            : bypass request from control unit
//   bypass_ack_o            : per-core bypass ack, bit NB_CORES = refill engine
//   core_fetch_busy_i       : per-core fetch outstanding
//   refill_idle_i           : refill engine has nothing outstanding
//   cache_en_o              : cache enable to datapath
//   flush_req_i/flush_ack_o : full flush four-phase handshake
//   sel_flush_req_i/_ack_o  : selective flush four-phase handshake
//   sel_flush_addr_i        : byte address for selective flush
//   tag_we_o/set_o/way_o    : tag invalidate write request
//   tag_gnt_i               : tag array grant
//   hit_i, trans_i          : per-core event pulses
//   clear_regs_i            : clear counters
//   enable_regs_i           : enable counting
//   hit_count_o/trans_count_o : counters
//   dbg_state_o             : current maintenance FSM state (observation only)
// -----------------------------------------------------------------------------
module icache_maint_sequencer
  import icache_maint_pkg::*;
#(
  parameter int NB_CORES     = 8,
  parameter int NB_WAYS      = 4,
  parameter int NB_SETS      = 64,
  parameter int LINE_BYTES   = 16,
  parameter int FEATURE_STAT = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        bypass_req_i,
  output logic [NB_CORES:0]           bypass_ack_o,
  input  logic [NB_CORES-1:0]         core_fetch_busy_i,
  input  logic                        refill_idle_i,
  output logic                        cache_en_o,
  input  logic                        flush_req_i,
  output logic                        flush_ack_o,
  input  logic                        sel_flush_req_i,
  input  logic [31:0]                 sel_flush_addr_i,
  output logic                        sel_flush_ack_o,
  output logic                        tag_we_o,
  output logic [$clog2(NB_SETS)-1:0]  tag_set_o,
  output logic [NB_WAYS-1:0]          tag_way_o,
  input  logic                        tag_gnt_i,
  input  logic [NB_CORES-1:0]         hit_i,
  input  logic [NB_CORES-1:0]         trans_i,
  input  logic                        clear_regs_i,
  input  logic                        enable_regs_i,
  output logic [31:0]                 hit_count_o,
  output logic [31:0]                 trans_count_o,
  output maint_state_e                dbg_state_o
);

  localparam int SET_W = $clog2(NB_SETS);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NB_SETS - 1);

  // ---------------------------------------------------------------------------
  // Maintenance FSM
  // ---------------------------------------------------------------------------
  maint_state_e       r_state;
  maint_state_e       w_state_nxt;
  logic               r_full;        // 1 = full flush in progress, 0 = selective
  logic               r_tag_we;
  logic [SET_W-1:0]   r_tag_set;
  logic [NB_WAYS-1:0] r_tag_way;
  logic               r_flush_ack;
  logic               r_sel_ack;
  logic               w_grant;
  logic               w_start;
  logic               w_nxt_write;
  logic [SET_W-1:0]   w_sel_set;

  assign w_grant     = r_tag_we & tag_gnt_i;
  assign w_start     = (r_state == IDLE) & (flush_req_i | sel_flush_req_i);
  assign w_sel_set   = SET_W'(addr_to_set(sel_flush_addr_i, OFF_W, SET_W));
  assign w_nxt_write = (w_state_nxt == FLUSH_WALK) | (w_state_nxt == SEL_INV);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:       if (flush_req_i || sel_flush_req_i) w_state_nxt = DRAIN;
      DRAIN:      if (refill_idle_i) w_state_nxt = r_full ? FLUSH_WALK : SEL_INV;
      // Leave only on the grant of the last set so the walk never wraps.
      FLUSH_WALK: if (w_grant && (r_tag_set == LAST_SET)) w_state_nxt = FLUSH_ACK;
      SEL_INV:    if (w_grant) w_state_nxt = SEL_ACK;
      FLUSH_ACK:  if (!flush_req_i) w_state_nxt = IDLE;
      SEL_ACK:    if (!sel_flush_req_i) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_full      <= 1'b0;
      r_tag_we    <= 1'b0;
      r_tag_set   <= '0;
      r_tag_way   <= '0;
      r_flush_ack <= 1'b0;
      r_sel_ack   <= 1'b0;
    end else begin
      r_tag_we    <= w_nxt_write;
      r_tag_way   <= w_nxt_write ? '1 : '0;
      r_flush_ack <= (w_state_nxt == FLUSH_ACK) | (w_state_nxt == SEL_ACK);
      r_sel_ack   <= (w_state_nxt == SEL_ACK);
      if (w_start) begin
        // Flush wins over selective flush; the address is captured here so
        // later changes on sel_flush_addr_i do not move the target set.
        r_full    <= flush_req_i;
        r_tag_set <= flush_req_i ? '0 : w_sel_set;
      end else if ((r_state == FLUSH_WALK) && w_grant && (r_tag_set != LAST_SET)) begin
        r_tag_set <= r_tag_set + SET_W'(1);
      end
    end
  end

  assign tag_we_o        = r_tag_we;
  assign tag_set_o       = r_tag_set;
  assign tag_way_o       = r_tag_way;
  assign flush_ack_o     = r_flush_ack;
  assign sel_flush_ack_o = r_sel_ack;
  assign dbg_state_o     = r_state;

  // ---------------------------------------------------------------------------
  // Bypass acknowledge: each bit follows the request only while its owner is
  // quiescent, so a core never sees the mode change mid-fetch.
  // ---------------------------------------------------------------------------
  logic [NB_CORES:0] r_bypass_ack;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bypass_ack <= '1;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        if (!core_fetch_busy_i[i]) r_bypass_ack[i] <= bypass_req_i;
      end
      if (refill_idle_i) r_bypass_ack[NB_CORES] <= bypass_req_i;
    end
  end

  assign bypass_ack_o = r_bypass_ack;
  assign cache_en_o   = ~r_bypass_ack[NB_CORES];

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  if (FEATURE_STAT != 0) begin : g_stat
    icache_perf_counter #(.N(NB_CORES)) u_hit_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pulse_i (hit_i),
      .en_i    (enable_regs_i),
      .clr_i   (clear_regs_i),
      .count_o (hit_count_o)
    );
    icache_perf_counter #(.N(NB_CORES)) u_trans_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pulse_i (trans_i),
      .en_i    (enable_regs_i),
      .clr_i   (clear_regs_i),
      .count_o (trans_count_o)
    );
  end else begin : g_no_stat
    assign hit_count_o   = '0;
    assign trans_count_o = '0;
  end

endmodule

// File: doc/icache_maint_sequencer.md
ICACHE_MAINT_SEQUENCER -- requirements
Module: icache_maint_sequencer

Interface
REQ-001 SHALL have parameters: NB_CORES, 8, number of fetching cores; NB_WAYS, 4, cache ways; NB_SETS, 64, sets (power of 2); LINE_BYTES, 16, line size (power of 2); FEATURE_STAT, 1, enables perf counters.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- bypass_req_i  in  1  bypass request from control unit
- bypass_ack_o  out  NB_CORES+1  per-core bypass ack; bit NB_CORES is the refill engine
- core_fetch_busy_i  in  NB_CORES  core i has a fetch outstanding
- refill_idle_i  in  1  refill engine has no refill outstanding
- cache_en_o  out  1  cache enabled, to datapath
- flush_req_i  in  1  full flush request, level
- flush_ack_o  out  1  flush done, level
- sel_flush_req_i  in  1  selective flush request, level
- sel_flush_addr_i  in  32  byte address to invalidate
- sel_flush_ack_o  out  1  selective flush done, level
- tag_we_o  out  1  tag invalidate write request
- tag_set_o  out  $clog2(NB_SETS)  set index
- tag_way_o  out  NB_WAYS  way mask
- tag_gnt_i  in  1  tag array grant; fetch path has priority
- hit_i  in  NB_CORES  per-core hit pulse
- trans_i  in  NB_CORES  per-core transaction pulse
- clear_regs_i  in  1  clear counters
- enable_regs_i  in  1  enable counting
- hit_count_o  out  32  accumulated hits
- trans_count_o  out  32  accumulated transactions

Function
REQ-004 Maintenance FSM states SHALL be IDLE, DRAIN, FLUSH_WALK, SEL_INV, FLUSH_ACK, SEL_ACK.
REQ-005 In IDLE, flush_req_i=1 SHALL go to DRAIN for a full flush; else sel_flush_req_i=1 SHALL go to DRAIN for a selective flush; flush wins when both are high.
REQ-006 DRAIN SHALL wait for refill_idle_i=1, then go to FLUSH_WALK (full) or SEL_INV (selective).
REQ-007 FLUSH_WALK SHALL drive tag_we_o=1 and tag_way_o all ones, with tag_set_o starting at 0 and incrementing on each cycle tag_we_o and tag_gnt_i are both high.
REQ-008 FLUSH_WALK SHALL go to FLUSH_ACK after the grant at set NB_SETS-1; the set counter SHALL not wrap into a second pass.
REQ-009 SEL_INV SHALL drive tag_we_o=1, tag_way_o all ones, and tag_set_o = sel_flush_addr_i[$clog2(LINE_BYTES) +: $clog2(NB_SETS)], with the address sampled on IDLE exit.
REQ-010 SEL_INV SHALL go to SEL_ACK on grant.
REQ-011 tag_we_o SHALL stay high and tag_set_o stable until granted.
REQ-012 FLUSH_ACK SHALL hold flush_ack_o=1 and return to IDLE on the cycle flush_req_i=0 (four-phase handshake).
REQ-013 SEL_ACK SHALL hold both sel_flush_ack_o=1 and flush_ack_o=1, and return to IDLE when sel_flush_req_i=0.
REQ-014 Acks SHALL be registered outputs, low in all other states.
REQ-015 bypass_ack_o[i] SHALL register bypass_req_i only in cycles where core_fetch_busy_i[i]=0, and otherwise hold its value.
REQ-016 bypass_ack_o[NB_CORES] SHALL follow the same rule gated by refill_idle_i=1.
REQ-017 cache_en_o SHALL equal ~bypass_ack_o[NB_CORES].
REQ-018 The bypass logic SHALL be independent of the maintenance FSM.
REQ-019 With enable_regs_i=1, each counter SHALL add popcount of its pulse vector per cycle, wrapping modulo 2^32.
REQ-020 clear_regs_i SHALL take priority over increment: the next value is 0 and that cycle's pulses are dropped.
REQ-021 With FEATURE_STAT=0, both counters SHALL be constant 0.

Reset
REQ-022 On rst_i, the block SHALL reset: FSM to IDLE; tag_we_o, flush_ack_o and sel_flush_ack_o to 0; tag_set_o to 0; tag_way_o to 0; bypass_ack_o all ones; cache_en_o 0; counters 0.
REQ-023 Reset mid-walk SHALL abandon the walk with no ack issued.

Structure
REQ-024 Package icache_maint_pkg SHALL hold the FSM state enum and an address-to-set index function.
REQ-025 Sub-module icache_perf_counter (popcount, enable, clear, 32-bit accumulate) SHALL be instantiated twice under FEATURE_STAT.

Verification
REQ-026 flush_req_i=1, tag_gnt_i=1 always, NB_SETS=64 -> 64 consecutive tag writes for sets 0..63, then flush_ack_o=1 until req drops.
REQ-027 flush with tag_gnt_i toggling every other cycle -> no set skipped or repeated; 128 cycles of tag_we_o.
REQ-028 sel_flush_addr_i=0x0000_1230, LINE_BYTES=16 -> single write at set 0x23, all ways; both acks high until sel_flush_req_i=0.
REQ-029 bypass_req_i 1->0 with core 3 busy for 5 cycles and refill_idle_i=1 -> all bits clear except bit 3, which clears 1 cycle after busy drops; cache_en_o=1.
REQ-030 hit_i=8'hFF enabled for 10 cycles -> hit_count_o=80; clear_regs_i concurrent with hits -> 0; rst_i during FLUSH_WALK -> IDLE with no ack.
